// File: rtl/serial_adder_controller.sv
// rtl/serial_adder_controller.sv - bit-serial adder around a single full_adder, LSB first
// Optional SERIAL_ADDER_OVERFLOW_EN adds a registered two's-complement overflow output.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_controller #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  input  logic             carry_in,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             carry_out_q, carry_out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  logic fa_s, fa_co;
  logic last_bit;

  full_adder u_fa (
    .a    (op1_q[0]),
    .b    (op2_q[0]),
    .cin  (c_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d     = state_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    sum_d       = sum_q;
    c_d         = c_q;
    carry_out_d = carry_out_q;
    cnt_d       = cnt_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          op1_d   = operand_1;
          op2_d   = operand_2;
          c_d     = carry_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
        sum_d = (sum_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
        op1_d = op1_q >> 1;
        op2_d = op2_q >> 1;
        c_d   = fa_co;
        cnt_d = cnt_q + CW'(1);
        if (last_bit) begin
          carry_out_d = fa_co;
`ifdef SERIAL_ADDER_OVERFLOW_EN
          ovf_d       = c_q ^ fa_co;
`endif
          state_d     = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      sum_q       <= '0;
      c_q         <= 1'b0;
      carry_out_q <= 1'b0;
      cnt_q       <= '0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      sum_q       <= sum_d;
      c_q         <= c_d;
      carry_out_q <= carry_out_d;
      cnt_q       <= cnt_d;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign ready     = ready_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = carry_out_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_controller.sv
// tb/tb_serial_adder_controller.sv - directed self-checking bench for serial_adder_controller
// Overflow checks are compiled in when SERIAL_ADDER_OVERFLOW_EN is defined.

module tb_serial_adder_controller;
  logic        clock = 1'b0;
  logic        reset;
  logic        start16, cin16, ready16, done16, cout16;
  logic [15:0] a16, b16, sum16;
  logic        start1, cin1, ready1, done1, cout1;
  logic [0:0]  a1, b1, sum1;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic        ovf16, ovf1;
`endif
  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  serial_adder_controller #(.WIDTH(16)) dut16 (
    .clock(clock), .reset(reset), .start(start16),
    .operand_1(a16), .operand_2(b16), .carry_in(cin16),
    .ready(ready16), .done(done16), .sum(sum16), .carry_out(cout16)
`ifdef SERIAL_ADDER_OVERFLOW_EN
    , .overflow(ovf16)
`endif
  );

  serial_adder_controller #(.WIDTH(1)) dut1 (
    .clock(clock), .reset(reset), .start(start1),
    .operand_1(a1), .operand_2(b1), .carry_in(cin1),
    .ready(ready1), .done(done1), .sum(sum1), .carry_out(cout1)
`ifdef SERIAL_ADDER_OVERFLOW_EN
    , .overflow(ovf1)
`endif
  );

  // Leaves the bench at the falling edge right after the accepting edge E0.
  task automatic accept16(input logic [15:0] a, input logic [15:0] b, input logic c);
    @(negedge clock);
    start16 = 1'b1; a16 = a; b16 = b; cin16 = c;
    @(negedge clock);
    start16 = 1'b0; a16 = 16'hDEAD; b16 = 16'hBEEF; cin16 = 1'b1;
  endtask

  // Returns the edge index k of the first done pulse (falling edge after E_k), or -1.
  task automatic wait_done16(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (done16) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    tests++; if (ready16 !== 1'b1) begin fails++; $display("FAIL reset_ready16 got %b exp 1", ready16); end
    tests++; if (done16 !== 1'b0) begin fails++; $display("FAIL reset_done16 got %b exp 0", done16); end
    tests++; if (sum16 !== 16'h0000) begin fails++; $display("FAIL reset_sum16 got %h exp 0000", sum16); end
    tests++; if (cout16 !== 1'b0) begin fails++; $display("FAIL reset_cout16 got %b exp 0", cout16); end
    tests++; if (ready1 !== 1'b1 || sum1 !== 1'b0) begin fails++; $display("FAIL reset_dut1 got ready=%b sum=%b exp 1/0", ready1, sum1); end
`ifdef SERIAL_ADDER_OVERFLOW_EN
    tests++; if (ovf16 !== 1'b0) begin fails++; $display("FAIL reset_ovf16 got %b exp 0", ovf16); end
`endif
    reset = 1'b0;
  endtask

  task automatic test_basic;
    int lat;
    accept16(16'h1234, 16'h4321, 1'b0);
    tests++; if (ready16 !== 1'b0) begin fails++; $display("FAIL basic_ready_run got %b exp 0", ready16); end
    wait_done16(lat);
    tests++; if (lat != 16) begin fails++; $display("FAIL basic_latency got %0d exp 16", lat); end
    tests++; if (ready16 !== 1'b0) begin fails++; $display("FAIL basic_ready_done got %b exp 0", ready16); end
    tests++; if (sum16 !== 16'h5555) begin fails++; $display("FAIL basic_sum got %h exp 5555", sum16); end
    tests++; if (cout16 !== 1'b0) begin fails++; $display("FAIL basic_cout got %b exp 0", cout16); end
    @(negedge clock);
    tests++; if (ready16 !== 1'b1 || done16 !== 1'b0) begin fails++; $display("FAIL basic_return_idle got ready=%b done=%b exp 1/0", ready16, done16); end
    repeat (4) @(negedge clock);
    tests++; if (sum16 !== 16'h5555) begin fails++; $display("FAIL basic_sum_hold got %h exp 5555", sum16); end
  endtask

  task automatic test_carry;
    int lat;
    accept16(16'hFFFF, 16'h0000, 1'b1);
    wait_done16(lat);
    tests++; if (lat != 16) begin fails++; $display("FAIL carry_latency got %0d exp 16", lat); end
    tests++; if (sum16 !== 16'h0000 || cout16 !== 1'b1) begin fails++; $display("FAIL carry_result got %h/%b exp 0000/1", sum16, cout16); end
`ifdef SERIAL_ADDER_OVERFLOW_EN
    tests++; if (ovf16 !== 1'b0) begin fails++; $display("FAIL carry_ovf got %b exp 0", ovf16); end
`endif
  endtask

  task automatic test_overflow;
    int lat;
    accept16(16'h7FFF, 16'h0001, 1'b0);
    wait_done16(lat);
    tests++; if (sum16 !== 16'h8000 || cout16 !== 1'b0) begin fails++; $display("FAIL ovf_result got %h/%b exp 8000/0", sum16, cout16); end
`ifdef SERIAL_ADDER_OVERFLOW_EN
    tests++; if (ovf16 !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b exp 1", ovf16); end
`endif
  endtask

  task automatic test_ignore_start;
    int first, pulses;
    first = -1; pulses = 0;
    accept16(16'h0F0F, 16'h0101, 1'b1);
    for (int k = 1; k <= 40; k++) begin
      // Drive at the falling edge so start is sampled at E3, E16 and E17 (DONE).
      start16 = (k == 3 || k == 16 || k == 17);
      a16 = 16'hAAAA; b16 = 16'h5555; cin16 = 1'b1;
      @(negedge clock);
      start16 = 1'b0;
      if (done16) begin
        pulses++;
        if (first < 0) first = k;
      end
      if (k == 16) begin
        tests++; if (sum16 !== 16'h1011 || cout16 !== 1'b0) begin fails++; $display("FAIL ignore_result got %h/%b exp 1011/0", sum16, cout16); end
      end
    end
    tests++; if (first != 16) begin fails++; $display("FAIL ignore_latency got %0d exp 16", first); end
    tests++; if (pulses != 1) begin fails++; $display("FAIL ignore_pulses got %0d exp 1", pulses); end
    tests++; if (ready16 !== 1'b1 || sum16 !== 16'h1011) begin fails++; $display("FAIL ignore_idle got ready=%b sum=%h exp 1/1011", ready16, sum16); end
  endtask

  task automatic test_reset_abort;
    int pulses, lat;
    pulses = 0;
    accept16(16'h00F0, 16'h0F00, 1'b0);
    repeat (7) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    tests++; if (ready16 !== 1'b1 || done16 !== 1'b0) begin fails++; $display("FAIL abort_state got ready=%b done=%b exp 1/0", ready16, done16); end
    tests++; if (sum16 !== 16'h0000 || cout16 !== 1'b0) begin fails++; $display("FAIL abort_sum got %h/%b exp 0000/0", sum16, cout16); end
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (done16) pulses++;
    end
    tests++; if (pulses != 0) begin fails++; $display("FAIL abort_no_done got %0d exp 0", pulses); end
    accept16(16'h0001, 16'h0001, 1'b0);
    wait_done16(lat);
    tests++; if (lat != 16 || sum16 !== 16'h0002) begin fails++; $display("FAIL abort_next got lat=%0d sum=%h exp 16/0002", lat, sum16); end
  endtask

  task automatic test_back_to_back;
    int lat;
    accept16(16'h8000, 16'h8000, 1'b0);
    wait_done16(lat);
    tests++; if (sum16 !== 16'h0000 || cout16 !== 1'b1) begin fails++; $display("FAIL b2b_first got %h/%b exp 0000/1", sum16, cout16); end
`ifdef SERIAL_ADDER_OVERFLOW_EN
    tests++; if (ovf16 !== 1'b1) begin fails++; $display("FAIL b2b_first_ovf got %b exp 1", ovf16); end
`endif
    accept16(16'h00FF, 16'h0F01, 1'b1);
    wait_done16(lat);
    tests++; if (lat != 16) begin fails++; $display("FAIL b2b_latency got %0d exp 16", lat); end
    tests++; if (sum16 !== 16'h1001 || cout16 !== 1'b0) begin fails++; $display("FAIL b2b_second got %h/%b exp 1001/0", sum16, cout16); end
`ifdef SERIAL_ADDER_OVERFLOW_EN
    tests++; if (ovf16 !== 1'b0) begin fails++; $display("FAIL b2b_second_ovf got %b exp 0", ovf16); end
`endif
  endtask

  task automatic test_width1;
    int lat;
    lat = -1;
    @(negedge clock);
    start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (done1) begin
        lat = k;
        break;
      end
    end
    tests++; if (lat != 1) begin fails++; $display("FAIL w1_latency got %0d exp 1", lat); end
    tests++; if (sum1 !== 1'b1 || cout1 !== 1'b1) begin fails++; $display("FAIL w1_result got %b/%b exp 1/1", sum1, cout1); end
    @(negedge clock);
    tests++; if (ready1 !== 1'b1 || done1 !== 1'b0) begin fails++; $display("FAIL w1_idle got ready=%b done=%b exp 1/0", ready1, done1); end
  endtask

  initial begin
    reset = 1'b1;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    test_reset;
    test_basic;
    test_carry;
    test_overflow;
    test_ignore_start;
    test_reset_abort;
    test_back_to_back;
    test_width1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_adder_controller.md
SERIAL_ADDER_CONTROLLER -- requirements
Module: serial_adder_controller

Interface
REQ-001 The module SHALL have one parameter: WIDTH, default 16, operand and sum width in bits; legal range 1..64.
REQ-002 The module SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-003 The ports SHALL be, one per line:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only while ready=1
- operand_1  input  WIDTH  first addend, captured on accept
- operand_2  input  WIDTH  second addend, captured on accept
- carry_in  input  1  initial carry, captured on accept
- ready  output  1  IDLE, can accept start
- done  output  1  one-cycle pulse, result valid
- sum  output  WIDTH  registered result
- carry_out  output  1  registered final carry
REQ-004 The module SHALL instantiate exactly one full_adder and compute all sum bits serially through it, LSB first.

Function
REQ-005 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-006 IDLE: ready=1, done=0. On an edge with start=1, the module SHALL capture operand_1, operand_2 and carry_in into internal shift/carry registers, clear the bit counter, and move to RUN.
REQ-007 RUN: ready=0. On each edge, the full_adder SHALL take the shift-register LSBs and the carry register. Its sum bit SHALL shift into the sum register MSB (sum shifts right), its carry SHALL load the carry register, both operand registers SHALL shift right, and the counter SHALL increment.
REQ-008 After the WIDTH-th RUN edge, the FSM SHALL enter DONE. sum SHALL then hold operand_1+operand_2+carry_in mod 2^WIDTH, and carry_out SHALL hold bit WIDTH of that sum.
REQ-009 DONE: done=1 and ready=0 for exactly one cycle, then unconditional return to IDLE.
REQ-010 Latency: with start accepted at edge E0, done SHALL be high between edges E(WIDTH) and E(WIDTH+1). ready SHALL return high after E(WIDTH+1). Throughput: one addition per WIDTH+2 cycles.
REQ-011 start while ready=0 SHALL be ignored without effect; operand changes after accept SHALL not affect the result.
REQ-012 sum and carry_out SHALL update only during RUN and SHALL hold their value through DONE and IDLE until the next accepted start.
REQ-013 The counter SHALL be $clog2(WIDTH+1) bits wide. WIDTH=1 SHALL complete in one RUN cycle.

Reset
REQ-014 reset=1 at an edge SHALL force IDLE, ready=1, done=0, sum=0, carry_out=0, and clear the counter, operand registers and carry register.
REQ-015 reset SHALL take priority over start and abort any RUN or DONE in progress; no done pulse SHALL follow an aborted operation.

Configuration
REQ-016 Macro SERIAL_ADDER_OVERFLOW_EN. When defined, the module SHALL add output port overflow (1 bit, registered). On the final RUN edge it SHALL load carry-into-MSB XOR carry-out-of-MSB (two's-complement overflow). It SHALL reset to 0 and hold like sum.
REQ-017 When SERIAL_ADDER_OVERFLOW_EN is undefined, the overflow port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-018 WIDTH=16, operands 0x1234 and 0x4321, carry_in=0 -> done at cycle 16 after accept; sum=0x5555, carry_out=0.
REQ-019 WIDTH=16, operands 0xFFFF and 0x0000, carry_in=1 -> sum=0x0000, carry_out=1; with macro, overflow=0.
REQ-020 WIDTH=16, operands 0x7FFF and 0x0001, carry_in=0, macro defined -> sum=0x8000, carry_out=0, overflow=1.
REQ-021 Start pulsed again at cycles 3 and 16 after accept, with new operands -> ignored; first result unchanged; exactly one done pulse.
REQ-022 Reset asserted at cycle 8 of RUN -> next cycle ready=1, sum=0, no done pulse; a following start 0x0001+0x0001 yields 0x0002.
REQ-023 WIDTH=1, operands 1 and 1, carry_in=1 -> done one cycle after the single RUN edge; sum=1, carry_out=1.
